bypass_tracker: RTL and testbench

- Producer side of the forwarding interface: decodes each instruction leaving F/D into a bypass control word and carries that word down the D/X, X/M and M/W stages.
- Drives the DXB, XMB and MWB words consumed by the forwarding unit.
- Generates the load-use interlock stall.
- Applies bubble, flush and freeze rules so that every bypass word stays aligned with its instruction in the pipeline.

---
 rtl/bypass_tracker.sv | 107 ++++++++++
 tb/tb_bypass_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bypass_tracker.sv
// Decodes the F/D instruction into a bypass word and carries it down D/X, X/M and M/W; raises the load-use stall.
// Latency: DXB one cycle after capture, XMB two, MWB three; hold freezes all words, stall/flush insert a bubble in D/X.
module bypass_tracker #(
    parameter int WORD_W      = 32,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] fd_insn,
    input  logic              fd_valid,
    input  logic              flush,
    input  logic              hold,
    output logic [WORD_W-1:0] DXB,
    output logic [WORD_W-1:0] XMB,
    output logic [WORD_W-1:0] MWB,
    output logic              stall
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    logic [4:0]        opcode, rd, rs, rt, alu_op;
    logic [4:0]        rd_a, rd_b, wr;
    logic              is_lw, is_sw, wr30;
    logic [WORD_W-1:0] w;
    logic [4:0]        dx_wr;
    logic              unused_fields;

    assign opcode        = fd_insn[31:27];
    assign rd            = fd_insn[26:22];
    assign rs            = fd_insn[21:17];
    assign rt            = fd_insn[16:12];
    assign alu_op        = fd_insn[6:2];
    assign unused_fields = ^{fd_insn[11:7], fd_insn[1:0]};

    always_comb begin
        rd_a  = 5'd0;
        rd_b  = 5'd0;
        wr    = 5'd0;
        is_lw = 1'b0;
        is_sw = 1'b0;
        wr30  = 1'b0;
        if (fd_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    rd_a = rs;
                    rd_b = rt;
                    wr   = rd;
                    wr30 = (alu_op == 5'b00000) || (alu_op == 5'b00001);
                end
                OP_ADDI: begin
                    rd_a = rs;
                    wr   = rd;
                    wr30 = 1'b1;
                end
                OP_LW: begin
                    rd_a  = rs;
                    wr    = rd;
                    is_lw = 1'b1;
                end
                OP_SW: begin
                    rd_a  = rs;
                    rd_b  = rd;
                    is_sw = 1'b1;
                end
                OP_BNE, OP_BLT: begin
                    rd_a = rd;
                    rd_b = rs;
                end
                OP_JR:   rd_a = rd;
                OP_JAL:  wr   = 5'd31;
                OP_SETX: wr   = 5'd30;
                OP_BEX:  rd_a = 5'd30;
                default: ;
            endcase
        end
    end

    assign w     = {wr30, is_sw, is_lw, 14'd0, wr, rd_b, rd_a};
    assign dx_wr = DXB[14:10];

    // sw data operand is served by the DMEM-data bypass, so only its address operand interlocks
    assign stall = LOAD_USE_EN && fd_valid && DXB[29] && (dx_wr != 5'd0)
                   && ((w[4:0] == dx_wr) || ((w[9:5] == dx_wr) && !w[30]))
                   && !flush && !hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            DXB <= '0;
            XMB <= '0;
            MWB <= '0;
        end else if (!hold) begin
            DXB <= (flush || stall) ? '0 : w;
            XMB <= DXB;
            MWB <= XMB;
        end
    end

endmodule

// File: tb/tb_bypass_tracker.sv
// Scoreboarded bench for bypass_tracker: expected stage words are queued as stimulus is driven and compared after each edge.
module tb_bypass_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_insn = '0;
    logic        fd_valid = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] DXB, XMB, MWB;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] dx;
        logic [31:0] xm;
        logic [31:0] mw;
    } trip_t;

    trip_t       exp_q[$];
    logic [31:0] m_dx = '0, m_xm = '0, m_mw = '0;

    bypass_tracker #(.WORD_W(32), .LOAD_USE_EN(1'b1)) dut (
        .clock    (clock),
        .reset    (reset),
        .fd_insn  (fd_insn),
        .fd_valid (fd_valid),
        .flush    (flush),
        .hold     (hold),
        .DXB      (DXB),
        .XMB      (XMB),
        .MWB      (MWB),
        .stall    (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] i, input logic v);
        logic [4:0] a, b, wr;
        logic       b29, b30, b31;
        a = 0; b = 0; wr = 0; b29 = 0; b30 = 0; b31 = 0;
        if (v) begin
            unique case (i[31:27])
                5'd0:        begin a = i[21:17]; b = i[16:12]; wr = i[26:22]; b31 = (i[6:2] <= 5'd1); end
                5'd5:        begin a = i[21:17]; wr = i[26:22]; b31 = 1; end
                5'd8:        begin a = i[21:17]; wr = i[26:22]; b29 = 1; end
                5'd7:        begin a = i[21:17]; b = i[26:22]; b30 = 1; end
                5'd2, 5'd6:  begin a = i[26:22]; b = i[21:17]; end
                5'd4:        a = i[26:22];
                5'd3:        wr = 5'd31;
                5'd21:       wr = 5'd30;
                5'd22:       a = 5'd30;
                default:     ;
            endcase
        end
        return {b31, b30, b29, 14'd0, wr, b, a};
    endfunction

    // one pipeline cycle: drive, check stall mid-cycle, queue the expected words, compare after the edge
    task automatic step(input string tag, input logic [31:0] insn, input logic v,
                        input logic f, input logic h, input logic r, input logic exp_stall);
        trip_t t;
        @(negedge clock);
        fd_insn = insn; fd_valid = v; flush = f; hold = h; reset = r;
        #1;
        chk({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
        if (r) begin
            m_dx = 0; m_xm = 0; m_mw = 0;
        end else if (!h) begin
            m_mw = m_xm;
            m_xm = m_dx;
            m_dx = (f || exp_stall) ? 32'd0 : ref_word(insn, v);
        end
        exp_q.push_back('{dx: m_dx, xm: m_xm, mw: m_mw});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd1, 32'd0);
        end else begin
            t = exp_q.pop_front();
            chk({tag, " DXB"}, DXB, t.dx);
            chk({tag, " XMB"}, XMB, t.xm);
            chk({tag, " MWB"}, MWB, t.mw);
        end
    endtask

    logic [31:0] add3, lw4, add6, sw4, lw0, add1, sw_a4, nop;
    logic [31:0] dec_tab[10];

    initial begin
        add3  = enc(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
        lw4   = enc(5'd8, 5'd4, 5'd5, 5'd0, 5'd0);
        add6  = enc(5'd0, 5'd6, 5'd4, 5'd7, 5'd0);
        sw4   = enc(5'd7, 5'd4, 5'd9, 5'd0, 5'd0);
        lw0   = enc(5'd8, 5'd0, 5'd2, 5'd0, 5'd0);
        add1  = enc(5'd0, 5'd1, 5'd0, 5'd0, 5'd0);
        sw_a4 = enc(5'd7, 5'd8, 5'd4, 5'd0, 5'd0);
        nop   = 32'd0;
        dec_tab = '{enc(5'd5, 5'd7, 5'd2, 5'd0, 5'd0), enc(5'd2, 5'd3, 5'd4, 5'd0, 5'd0),
                    enc(5'd6, 5'd5, 5'd6, 5'd0, 5'd0), enc(5'd4, 5'd31, 5'd0, 5'd0, 5'd0),
                    enc(5'd3, 5'd1, 5'd1, 5'd1, 5'd0), enc(5'd21, 5'd2, 5'd2, 5'd0, 5'd0),
                    enc(5'd22, 5'd0, 5'd0, 5'd0, 5'd0), enc(5'd1, 5'd9, 5'd9, 5'd9, 5'd0),
                    enc(5'd0, 5'd8, 5'd10, 5'd11, 5'd2), enc(5'd31, 5'd8, 5'd9, 5'd10, 5'd0)};

        @(posedge clock);
        #1;
        step("reset", add3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        step("add3", add3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add3 word", DXB, 32'h8000_0C41);
        step("bub1", nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add3 on XMB", XMB, 32'h8000_0C41);
        step("bub2", nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add3 on MWB", MWB, 32'h8000_0C41);

        step("lw4", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw4 word", DXB, 32'h2000_1005);
        step("lu stall", add6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu after", add6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add6 word", DXB, 32'h8000_18E4);

        step("lw4 b", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sw data", sw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sw4 word", DXB, 32'h4000_0089);

        step("lw0", lw0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r0 target", add1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step("lw4 c", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sw addr", sw_a4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("sw addr2", sw_a4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step("lw4 d", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("invalid", add6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        step("lw4 e", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("flush", add6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush XMB lw", XMB, 32'h2000_1005);

        step("fill add3", add3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fill lw4", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold", add6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold keeps lw", DXB, 32'h2000_1005);
        step("hold+reset", add6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("post reset", add3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post reset word", DXB, 32'h8000_0C41);

        step("lw4 f", lw4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stall+reset", add6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("after rst", add6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++)
            step($sformatf("decode%0d", i), dec_tab[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drain1", nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drain2", nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
